vector_checker: RTL and testbench
=================================

Name: vector_checker

Overview:
- Hardware response checker on the consuming side of the stimulus/response loop: a vector driver applies {a, b} to a unit under test, and this block accepts the resulting {actual c, expected c} pairs.
- Accepts the pairs over a valid/ready stream and buffers them in a small FIFO.
- Compares each pair, emits a mismatch record stream, and keeps pass/fail statistics for a run of NUM_VECTORS vectors.
- Sits between the unit-under-test wrapper and a logging/readout agent.

Parameters:
- WIDTH, 4: width of a, b, actual and expected results.
- NUM_VECTORS, 8: vectors per run; min 1, max 2**IDX_W-1.
- FIFO_DEPTH, 4: input buffer entries; power of 2, >=2.
- IDX_W, 8: vector index width.
- ERR_CNT_W, 8: error counter width; the counter saturates.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_stim  in  2*WIDTH  {a,b}, carried through for logging.
- in_act  in  WIDTH  actual UUT output c.
- in_exp  in  WIDTH  expected c.
- err_valid  out  1  mismatch record valid.
- err_ready  in  1  record consumed when err_valid && err_ready.
- err_idx  out  IDX_W  vector index of the mismatch.
- err_stim  out  2*WIDTH  stimulus of the mismatch.
- err_act  out  WIDTH  actual value of the mismatch.
- err_exp  out  WIDTH  expected value of the mismatch.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_CNT_W  saturating count of mismatches.
- vec_count  out  IDX_W  vectors compared this run.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; FIFO emptied.
  - All outputs 0: in_ready, err_valid, err_idx/stim/act/exp, busy, done, pass, err_count, vec_count.
- FSM states: IDLE, RUN, DRAIN, DONE (one-hot or binary).
  - IDLE/DONE --start--> RUN. On this transition, clear err_count, vec_count, the accept counter and the FIFO. done and pass drop the next cycle.
  - RUN: in_ready = !fifo_full && (accepted < NUM_VECTORS). When accepted reaches NUM_VECTORS, go to DRAIN.
  - DRAIN: in_ready=0. Go to DONE when the FIFO is empty, err_valid=0 and vec_count==NUM_VECTORS.
  - start in RUN or DRAIN is ignored.
- FIFO:
  - Entry is {stim, act, exp}; write on input handshake.
  - Registered output; one-cycle latency from accept to compare eligibility.
  - Pointer wrap is modulo FIFO_DEPTH with an extra wrap bit to distinguish full from empty.
  - Simultaneous push and pop when full is legal: in_ready reflects full only, so the push waits one cycle.
- Compare stage:
  - Pops the head when FIFO is non-empty and (err_valid==0 || err_ready).
  - On pop: compare act==exp, increment vec_count.
  - On mismatch: increment err_count (saturates at all-ones), load the err_* record with err_idx = the pre-increment vec_count, and set err_valid the next cycle.
  - err_valid holds and the err_* fields stay stable until err_ready. While the record is pending, the FIFO does not pop, so backpressure propagates to in_ready.
  - If a record handshakes and the next head mismatches in the same cycle, the new record loads back-to-back with no bubble.
- Throughput: 1 vector/cycle when no mismatch is stalled.
- X on in_act/in_exp when in_valid=0 must not affect state.
- Asserting rst_n=0 mid-run returns the block to the reset state immediately; pending records are lost.

Decomposition:
- Shared package vector_checker_pkg holds:
  - the state enum chk_state_e {IDLE, RUN, DRAIN, DONE};
  - the localparam function for the pointer width, clog2(FIFO_DEPTH);
  - the entry struct typedef, parameterised through WIDTH at module level.
- One sub-module: chk_fifo, a synchronous FIFO with push/pop/full/empty/flush ports, parameters DEPTH and DW. The FSM, counters and compare logic stay in vector_checker.

Test Plan:
1. Clean run: start, 8 vectors with act==exp, in_valid held high, err_ready=1.
   -> in_ready high for 8 cycles; done asserts ≤3 cycles after the last accept; pass=1, err_count=0, vec_count=8, err_valid never high.
2. Single mismatch at vector 3: stim=8'h3C, act=4'h5, exp=4'h4.
   -> err_valid pulses once with err_idx=3, err_stim=8'h3C, err_act=4'h5, err_exp=4'h4; final err_count=1, pass=0.
3. Backpressure: all vectors mismatch, err_ready=0 for 10 cycles, then 1.
   -> The first record holds stable; the FIFO fills (4 entries) and in_ready drops. After release, 8 records emerge with err_idx 0..7 in order; err_count=8.
4. Saturation: ERR_CNT_W=2, 8 mismatches.
   -> err_count sticks at 3; vec_count=8; pass=0.
5. Reset mid-run: rst_n low after 4 accepts.
   -> All outputs 0 asynchronously. A following start and 8 clean vectors give pass=1, vec_count=8.
6. Restart from DONE: start pulse in DONE with err_count=2.
   -> Next cycle done=0, pass=0, err_count=0, busy=1. A start pulse issued during RUN has no effect.

Source files
------------

// File: rtl/vector_checker_pkg.sv
// rtl/vector_checker_pkg.sv - shared types and helpers for the vector checker
package vector_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    // Pointer index width for a FIFO of the given depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // The FIFO entry layout depends on WIDTH, so the packed struct
    // {stim, act, exp} is declared inside vector_checker where WIDTH is known.

endpackage

// File: rtl/chk_fifo.sv
// rtl/chk_fifo.sv - synchronous FIFO with wrap-bit pointers and flush
module chk_fifo
    import vector_checker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Equal indices: wrap bits equal means empty, different means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush discards all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; data only changes on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vector_checker.sv
// rtl/vector_checker.sv - response checker with mismatch record stream and run statistics
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int NUM_VECTORS = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int IDX_W       = 8,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_stim,
    input  logic [WIDTH-1:0]     in_act,
    input  logic [WIDTH-1:0]     in_exp,
    output logic                 err_valid,
    input  logic                 err_ready,
    output logic [IDX_W-1:0]     err_idx,
    output logic [2*WIDTH-1:0]   err_stim,
    output logic [WIDTH-1:0]     err_act,
    output logic [WIDTH-1:0]     err_exp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [IDX_W-1:0]     vec_count
);

    typedef struct packed {
        logic [2*WIDTH-1:0] stim;
        logic [WIDTH-1:0]   act;
        logic [WIDTH-1:0]   exp;
    } entry_t;

    localparam int               DW      = $bits(entry_t);
    localparam logic [IDX_W-1:0] NUM_V   = IDX_W'(NUM_VECTORS);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    chk_state_e       state;
    chk_state_e       state_nxt;
    logic [IDX_W-1:0] acc_cnt;
    entry_t           wr_entry;
    entry_t           head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             start_go;
    logic             mismatch;

    assign start_go = start && ((state == IDLE) || (state == DONE));
    assign wr_entry = '{stim: in_stim, act: in_act, exp: in_exp};
    assign push     = in_valid && in_ready;
    // A pending record blocks the compare stage, which backs up into the FIFO.
    assign pop      = busy && !fifo_empty && (!err_valid || err_ready);
    assign mismatch = pop && (head.act != head.exp);

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    chk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start_go),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and input-ready decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                in_ready = !fifo_full && (acc_cnt < NUM_V);
                if (acc_cnt == NUM_V)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !err_valid && (vec_count == NUM_V))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accept, compare and saturating error counters; all cleared by a new run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt   <= '0;
            vec_count <= '0;
            err_count <= '0;
        end else if (start_go) begin
            acc_cnt   <= '0;
            vec_count <= '0;
            err_count <= '0;
        end else begin
            if (push)
                acc_cnt <= acc_cnt + IDX_ONE;
            if (pop)
                vec_count <= vec_count + IDX_ONE;
            if (mismatch && (err_count != '1))
                err_count <= err_count + ERR_ONE;
        end
    end

    // Mismatch record: loads on a failing pop (even in the cycle the previous
    // record hands off), otherwise clears once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_idx   <= '0;
            err_stim  <= '0;
            err_act   <= '0;
            err_exp   <= '0;
        end else if (mismatch) begin
            err_valid <= 1'b1;
            err_idx   <= vec_count;
            err_stim  <= head.stim;
            err_act   <= head.act;
            err_exp   <= head.exp;
        end else if (err_ready) begin
            err_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vector_checker.sv
// tb/tb_vector_checker.sv - table-driven self-checking bench for vector_checker
module tb_vector_checker;

    typedef struct {
        logic [7:0] stim;
        logic [3:0] act;
        logic [3:0] exp;
        bit         exp_err;
    } vec_t;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] stim;
        logic [3:0] act;
        logic [3:0] exp;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_stim;
    logic [3:0] in_act;
    logic [3:0] in_exp;
    logic       err_valid;
    logic       err_ready;
    logic [7:0] err_idx;
    logic [7:0] err_stim;
    logic [3:0] err_act;
    logic [3:0] err_exp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] vec_count;

    logic       s_in_ready;
    logic       s_err_valid;
    logic [7:0] s_err_idx;
    logic [7:0] s_err_stim;
    logic [3:0] s_err_act;
    logic [3:0] s_err_exp;
    logic       s_busy;
    logic       s_done;
    logic       s_pass;
    logic [1:0] s_err_count;
    logic [7:0] s_vec_count;

    int   passed = 0;
    int   total  = 0;
    int   rdy_cycles = 0;
    int   viol = 0;
    bit   hold_pend = 0;
    rec_t held;
    rec_t log_q[$];

    vec_t t_clean[8];
    vec_t t_one[8];
    vec_t t_all[8];
    vec_t t_two[8];
    vec_t cur[8];

    always #5 clk = ~clk;

    vector_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_stim(in_stim), .in_act(in_act), .in_exp(in_exp),
        .err_valid(err_valid), .err_ready(err_ready),
        .err_idx(err_idx), .err_stim(err_stim), .err_act(err_act), .err_exp(err_exp),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_count(vec_count)
    );

    vector_checker #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_stim(in_stim), .in_act(in_act), .in_exp(in_exp),
        .err_valid(s_err_valid), .err_ready(err_ready),
        .err_idx(s_err_idx), .err_stim(s_err_stim), .err_act(s_err_act), .err_exp(s_err_exp),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err_count), .vec_count(s_vec_count)
    );

    // Record log, ready-cycle count and record-stability watch, all off-edge.
    always @(negedge clk) begin
        if (in_ready)
            rdy_cycles++;
        if (err_valid && err_ready)
            log_q.push_back('{err_idx, err_stim, err_act, err_exp});
        if (hold_pend && (!err_valid || (rec_t'({err_idx, err_stim, err_act, err_exp}) != held)))
            viol++;
        hold_pend = rst_n && err_valid && !err_ready;
        held      = '{err_idx, err_stim, err_act, err_exp};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  0);
        check({tag, "_err_valid"}, 32'(err_valid), 0);
        check({tag, "_err_rec"},   32'({err_idx, err_stim, err_act, err_exp}), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_pass"},      32'(pass), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
        check({tag, "_vec_count"}, 32'(vec_count), 0);
    endtask

    task automatic start_run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Offer cur[0..n-1] in order; returns just after the last accepting edge.
    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            in_valid = 1'b1;
            in_stim  = cur[i].stim;
            in_act   = cur[i].act;
            in_exp   = cur[i].exp;
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready)
                check("accept_timeout", 32'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_act   = 'x;
        in_exp   = 'x;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 300);
        check("done_reached", 32'(done), 1);
    endtask

    task automatic check_log(input string tag);
        int   n_exp;
        int   n;
        rec_t want;
        n_exp = 0;
        for (int i = 0; i < 8; i++)
            if (cur[i].exp_err) n_exp++;
        check({tag, "_rec_count"}, 32'(log_q.size()), 32'(n_exp));
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (cur[i].exp_err && n < log_q.size()) begin
                want = '{8'(i), cur[i].stim, cur[i].act, cur[i].exp};
                check({tag, "_rec"}, 32'(log_q[n]), 32'(want));
                n++;
            end
        end
    endtask

    initial begin
        int k;
        t_clean = '{'{8'h00,4'h0,4'h0,0}, '{8'h11,4'h2,4'h2,0}, '{8'h23,4'h5,4'h5,0}, '{8'h34,4'h7,4'h7,0},
                    '{8'h45,4'h9,4'h9,0}, '{8'h56,4'hB,4'hB,0}, '{8'h67,4'hD,4'hD,0}, '{8'hFF,4'hE,4'hE,0}};
        t_one   = '{'{8'h12,4'h3,4'h3,0}, '{8'h21,4'h3,4'h3,0}, '{8'h22,4'h4,4'h4,0}, '{8'h3C,4'h5,4'h4,1},
                    '{8'h44,4'h8,4'h8,0}, '{8'h15,4'h6,4'h6,0}, '{8'h70,4'h7,4'h7,0}, '{8'h81,4'h9,4'h9,0}};
        t_all   = '{'{8'hA0,4'h1,4'h0,1}, '{8'hA1,4'h2,4'h1,1}, '{8'hA2,4'h3,4'h2,1}, '{8'hA3,4'h4,4'h3,1},
                    '{8'hA4,4'h5,4'h4,1}, '{8'hA5,4'h6,4'h5,1}, '{8'hA6,4'h7,4'h6,1}, '{8'hA7,4'h8,4'h7,1}};
        t_two   = '{'{8'h01,4'h1,4'h1,0}, '{8'h02,4'hF,4'h2,1}, '{8'h03,4'h3,4'h3,0}, '{8'h04,4'h4,4'h4,0},
                    '{8'h05,4'h5,4'h5,0}, '{8'h06,4'h6,4'h6,0}, '{8'h07,4'h0,4'h7,1}, '{8'h08,4'h8,4'h8,0}};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; err_ready = 1'b1;
        in_stim = '0; in_act = 'x; in_exp = 'x;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Clean run.
        cur = t_clean; log_q.delete(); rdy_cycles = 0;
        start_run();
        drive(8);
        wait_done(k);
        check("clean_done_latency_le3", 32'(k <= 3), 1);
        check("clean_rdy_cycles", 32'(rdy_cycles), 8);
        check("clean_pass", 32'(pass), 1);
        check("clean_err_count", 32'(err_count), 0);
        check("clean_vec_count", 32'(vec_count), 8);
        check("clean_busy", 32'(busy), 0);
        check_log("clean");

        // Single mismatch at vector 3.
        cur = t_one; log_q.delete();
        start_run();
        drive(8);
        wait_done(k);
        check("one_err_count", 32'(err_count), 1);
        check("one_pass", 32'(pass), 0);
        check_log("one");

        // Backpressure with every vector mismatching; also saturates dut_sat.
        cur = t_all; log_q.delete(); viol = 0;
        err_ready = 1'b0;
        start_run();
        fork
            drive(8);
            begin
                repeat (10) @(negedge clk);
                check("bp_in_ready_low", 32'(in_ready), 0);
                check("bp_err_valid", 32'(err_valid), 1);
                check("bp_head_rec", 32'({err_idx, err_stim, err_act, err_exp}),
                      32'({8'h00, 8'hA0, 4'h1, 4'h0}));
                check("bp_vec_count", 32'(vec_count), 1);
                @(posedge clk); #1 err_ready = 1'b1;
            end
        join
        wait_done(k);
        check("bp_err_count", 32'(err_count), 8);
        check("bp_stable", 32'(viol), 0);
        check_log("bp");
        check("sat_err_count", 32'(s_err_count), 3);
        check("sat_vec_count", 32'(s_vec_count), 8);
        check("sat_pass", 32'(s_pass), 0);
        check("sat_done", 32'(s_done), 1);

        // Reset in the middle of a run.
        cur = t_one;
        start_run();
        drive(4);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        cur = t_clean; log_q.delete();
        start_run();
        drive(8);
        wait_done(k);
        check("after_reset_pass", 32'(pass), 1);
        check("after_reset_vec_count", 32'(vec_count), 8);

        // Restart from DONE holding two errors, then ignore a start during RUN.
        cur = t_two; log_q.delete();
        start_run();
        drive(8);
        wait_done(k);
        check("two_err_count", 32'(err_count), 2);
        check_log("two");
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("restart_done", 32'(done), 0);
        check("restart_pass", 32'(pass), 0);
        check("restart_err_count", 32'(err_count), 0);
        check("restart_busy", 32'(busy), 1);
        cur = t_clean; log_q.delete();
        fork
            drive(8);
            begin
                int w;
                w = 0;
                while (vec_count < 3 && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                check("run_start_busy", 32'(busy), 1);
                check("run_start_no_clear", 32'(vec_count >= 3), 1);
            end
        join
        wait_done(k);
        check("restart_run_pass", 32'(pass), 1);
        check("restart_run_vec_count", 32'(vec_count), 8);
        check_log("restart");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
